// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXECUTE/WRITEBACK control FSM for the reduced RISC-V core
//   clk, rst            : clock, synchronous active-high reset
//   mem_ready, instr    : instruction memory handshake and IR contents
//   EQ                  : ALU equality result for branches
//   IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc : per-state datapath controls
//   illegal, retired    : sticky illegal-instruction flag, saturating retired count
module multicycle_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  EQ,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [2:0]            ALUctrl,
    output logic                  ALUsrc,
    output logic [1:0]            ImmSrc,
    output logic                  PCsrc,
    output logic                  illegal,
    output logic [CNT_WIDTH-1:0]  retired
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC_I, EXEC_B, WB, TRAP} state_t;
    state_t state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic is_addi, is_br, unused_bits;
    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign is_addi = opcode == 7'b0010011 && funct3 == 3'b000;
    assign is_br   = opcode == 7'b1100011 && funct3[2:1] == 2'b00;
    assign unused_bits = ^{instr[DATA_WIDTH-1:15], instr[11:7]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            case (state)
                FETCH:  state <= mem_ready ? DECODE : FETCH;
                DECODE: begin
                    state   <= is_addi ? EXEC_I : is_br ? EXEC_B : TRAP;
                    illegal <= illegal | ~(is_addi | is_br);
                end
                EXEC_I: state <= WB;
                WB, EXEC_B: begin
                    state   <= FETCH;
                    retired <= retired == '1 ? retired : retired + CNT_WIDTH'(1);
                end
                TRAP:   state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end
    // enables are masked during reset so an abandoned instruction never writes
    always_comb begin
        IRWrite  = !rst && state == FETCH && mem_ready;
        PCWrite  = !rst && (state == WB || state == EXEC_B);
        RegWrite = !rst && state == WB;
        ALUctrl  = state == EXEC_B ? 3'b001 : 3'b000;
        ALUsrc   = state == EXEC_I || state == WB;
        ImmSrc   = state == EXEC_B ? 2'b11 : (state == EXEC_I || state == WB) ? 2'b01 : 2'b00;
        // funct3[0] distinguishes bne from beq, so it inverts the taken sense
        PCsrc    = state == EXEC_B && (EQ ^ instr[12]);
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed bench with a queue-based schedule model of the sequencer
module tb_multicycle_sequencer;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BNE  = 32'h00209463;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] ILL  = 32'h00000033;
    logic clk = 1'b0;
    logic rst, mem_ready, EQ;
    logic [31:0] instr;
    logic IRWrite, PCWrite, RegWrite, ALUsrc, PCsrc, illegal;
    logic [2:0] ALUctrl;
    logic [1:0] ImmSrc;
    logic [15:0] retired;
    logic IRWrite2, PCWrite2, RegWrite2, ALUsrc2, PCsrc2, illegal2;
    logic [2:0] ALUctrl2;
    logic [1:0] ImmSrc2;
    logic [1:0] retired2;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .instr(instr), .EQ(EQ),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUctrl(ALUctrl),
        .ALUsrc(ALUsrc), .ImmSrc(ImmSrc), .PCsrc(PCsrc), .illegal(illegal), .retired(retired)
    );
    multicycle_sequencer #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .instr(instr), .EQ(EQ),
        .IRWrite(IRWrite2), .PCWrite(PCWrite2), .RegWrite(RegWrite2), .ALUctrl(ALUctrl2),
        .ALUsrc(ALUsrc2), .ImmSrc(ImmSrc2), .PCsrc(PCsrc2), .illegal(illegal2), .retired(retired2)
    );

    // Model: each accepted fetch schedules one control word per following cycle.
    // pcs: 0 = PCsrc low, 1 = taken when EQ, 2 = taken when not EQ
    typedef struct packed {
        logic       dec;
        logic       pcw;
        logic       rw;
        logic [2:0] alu;
        logic       src;
        logic [1:0] imm;
        logic [1:0] pcs;
        logic       ret;
    } word_t;
    word_t q[$];
    bit trapped, m_ill, started;
    int cnt, cnt2;

    always @(posedge clk) begin
        word_t w;
        started <= 1'b1;
        if (rst) begin
            q.delete();
            trapped = 0; m_ill = 0; cnt = 0; cnt2 = 0;
        end else if (!trapped) begin
            if (q.size() == 0) begin
                if (mem_ready) q.push_back('{dec:1, default:0});
            end else begin
                w = q.pop_front();
                if (w.dec) begin
                    if (instr[6:0] == 7'h13 && instr[14:12] == 3'd0) begin
                        q.push_back('{src:1, imm:2'b01, default:0});
                        q.push_back('{pcw:1, rw:1, src:1, imm:2'b01, ret:1, default:0});
                    end else if (instr[6:0] == 7'h63 && instr[14:13] == 2'd0)
                        q.push_back('{pcw:1, alu:3'b001, imm:2'b11, pcs:(instr[12] ? 2'd2 : 2'd1), ret:1, default:0});
                    else begin
                        trapped = 1; m_ill = 1;
                    end
                end
                if (w.ret) begin
                    cnt  = cnt  < 65535 ? cnt + 1 : cnt;
                    cnt2 = cnt2 < 3 ? cnt2 + 1 : cnt2;
                end
            end
        end
    end

    always @(negedge clk) if (started) begin
        logic [9:0] e, a, a2;
        word_t w;
        if (trapped) e = '0;
        else if (q.size() == 0) e = {mem_ready, 9'b0};
        else begin
            w = q[0];
            e = {1'b0, w.pcw, w.rw, w.alu, w.src, w.imm, w.pcs == 1 ? EQ : w.pcs == 2 ? ~EQ : 1'b0};
        end
        if (rst) e[9:7] = 3'b000;
        a  = {IRWrite, PCWrite, RegWrite, ALUctrl, ALUsrc, ImmSrc, PCsrc};
        a2 = {IRWrite2, PCWrite2, RegWrite2, ALUctrl2, ALUsrc2, ImmSrc2, PCsrc2};
        chk("ctrl", 32'(a), 32'(e));
        chk("ctrl2", 32'(a2), 32'(e));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("illegal2", 32'(illegal2), 32'(m_ill));
        chk("retired", 32'(retired), 32'(cnt));
        chk("retired2", 32'(retired2), 32'(cnt2));
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // accept one instruction with a single-cycle ready pulse, leave it in DECODE
    task automatic fetch(logic [31:0] ins);
        instr = ins; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    initial begin
        int sat[5] = '{1, 2, 3, 3, 3};
        rst = 1'b1; mem_ready = 1'b0; EQ = 1'b0; instr = '0;
        tick(2);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_illegal", 32'(illegal), 0);
        rst = 1'b0;
        fetch(ADDI);
        tick();
        chk("addi_exec_src", 32'({ALUsrc, ImmSrc, RegWrite, PCWrite}), 32'b1_01_0_0);
        tick();
        chk("addi_wb", 32'({RegWrite, PCWrite, PCsrc, ALUctrl}), 32'b1_1_0_000);
        tick();
        chk("addi_retired", 32'(retired), 1);
        EQ = 1'b0; fetch(BNE); tick();
        chk("bne_eq0", 32'({ALUctrl, ImmSrc, PCWrite, PCsrc, RegWrite}), 32'b001_11_1_1_0);
        tick();
        EQ = 1'b1; fetch(BNE); tick();
        chk("bne_eq1", 32'(PCsrc), 0);
        tick();
        EQ = 1'b0; fetch(BEQ); tick();
        chk("beq_eq0", 32'(PCsrc), 0);
        tick();
        EQ = 1'b1; fetch(BEQ); tick();
        chk("beq_eq1", 32'(PCsrc), 1);
        tick();
        chk("br_retired", 32'(retired), 5);
        instr = ADDI;
        for (int i = 0; i < 5; i++) begin
            chk("wait_idle", 32'({IRWrite, PCWrite, RegWrite}), 0);
            tick();
        end
        mem_ready = 1'b1; #1;
        chk("wait_irwrite", 32'(IRWrite), 1);
        tick(); mem_ready = 1'b0;
        tick(3);
        chk("wait_retired", 32'(retired), 6);
        fetch(ILL); tick();
        chk("trap_illegal", 32'(illegal), 1);
        mem_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = (i % 2 == 0) ? ADDI : BNE;
            tick();
        end
        chk("trap_hold", 32'({illegal, IRWrite, PCWrite, RegWrite}), 32'b1000);
        chk("trap_retired", 32'(retired), 6);
        mem_ready = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk("trap_rst", 32'({illegal, retired}), 0);
        fetch(ADDI); tick(2);
        rst = 1'b1; #1;
        chk("rst_in_wb", 32'({RegWrite, PCWrite}), 0);
        tick(); rst = 1'b0;
        chk("rst_in_wb_retired", 32'(retired), 0);
        mem_ready = 1'b1; #1;
        chk("rst_in_wb_fetch", 32'(IRWrite), 1);
        for (int i = 0; i < 5; i++) begin
            tick(4);
            chk("sat_retired2", 32'(retired2), 32'(sat[i]));
            chk("sat_retired", 32'(retired), 32'(i + 1));
        end
        mem_ready = 1'b0;
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the reduced RISC-V core. It replaces single-cycle decode with a FETCH/DECODE/EXECUTE/WRITEBACK sequence.
- Drives the shared ALU, register file, immediate extender and PC through per-state enables.
- Waits on an instruction-memory ready handshake.
- Flags illegal instructions and counts retired instructions.

Parameters:
DATA_WIDTH, 32, instruction width
CNT_WIDTH, 16, width of retired-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
mem_ready  input  1  instruction memory has valid data on instr this cycle
instr  input  DATA_WIDTH  instruction register contents (IR output)
EQ  input  1  ALU compare result, 1 when operands equal
IRWrite  output  1  load instruction register
PCWrite  output  1  update PC this cycle
RegWrite  output  1  register file write enable
ALUctrl  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor
ALUsrc  output  1  0 = rs2, 1 = immediate
ImmSrc  output  2  00 R, 01 I, 10 J, 11 B
PCsrc  output  1  0 = PC+4, 1 = PC+branch offset
illegal  output  1  sticky illegal-instruction flag
retired  output  CNT_WIDTH  count of completed instructions, saturating

Behaviour:
- Reset (rst high at posedge):
  - state <= FETCH, illegal <= 0, retired <= 0.
  - rst has priority over every transition, including mid-instruction; a partially executed instruction is abandoned with no write.
- Output defaults in every state unless listed: IRWrite=0, PCWrite=0, RegWrite=0, ALUctrl=000, ALUsrc=0, ImmSrc=00, PCsrc=0.
  - Outputs are combinational from state.
  - In EXEC_B, PCsrc is also a function of EQ and funct3.
- FETCH:
  - IRWrite = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay, with no bound on the wait.
- DECODE: decode opcode = instr[6:0] and funct3 = instr[14:12].
  - opcode 0010011 with funct3 000 (addi) -> EXEC_I.
  - opcode 1100011 with funct3 000 (beq) or 001 (bne) -> EXEC_B.
  - anything else -> TRAP.
- EXEC_I: ALUsrc=1, ImmSrc=01, ALUctrl=000 -> WB.
- WB:
  - RegWrite=1, ALUsrc=1, ImmSrc=01, ALUctrl=000 (ALU result held for write).
  - PCWrite=1, PCsrc=0.
  - retired increments -> FETCH.
- EXEC_B:
  - ALUsrc=0, ImmSrc=11, ALUctrl=001, PCWrite=1.
  - beq: PCsrc=EQ. bne: PCsrc=~EQ.
  - retired increments -> FETCH.
- TRAP:
  - all enables 0; illegal=1, registered on entry.
  - Stays in TRAP until rst; no further fetches or writes.
- Latency with mem_ready high on the first FETCH cycle:
  - addi: 4 cycles, FETCH to FETCH.
  - beq/bne: 3 cycles.
  - Each FETCH wait cycle adds 1.
- retired saturates at 2^CNT_WIDTH-1 and never wraps.
- Exactly one of RegWrite/PCWrite pairs is active per instruction.
  - PCWrite is high for exactly one cycle per retired instruction.
  - IRWrite is high for exactly one cycle per fetch.
- instr is sampled only in DECODE and EXEC_B; changes on instr in other states have no effect.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready held 1 -> states FETCH,DECODE,EXEC_I,WB. RegWrite=1 only in WB. PCWrite=1,PCsrc=0 in WB. retired=1 after 4 cycles.
- bne (0x00209463), EQ=0 -> EXEC_B on cycle 3 with ALUctrl=001, ImmSrc=11, PCWrite=1, PCsrc=1, RegWrite=0. Repeat with EQ=1 -> PCsrc=0. beq (funct3=000) gives the inverse.
- mem_ready low for 5 cycles then high -> FETCH held 6 cycles, IRWrite pulses once on the 6th, and no other enables are asserted meanwhile.
- Illegal opcode 0x00000033 (R-type add) -> TRAP after DECODE. illegal=1 persists for 20 cycles, all enables 0. rst for 1 cycle -> FETCH, illegal=0, retired=0.
- rst asserted during WB of an addi -> no RegWrite/PCWrite that cycle, state FETCH next cycle, retired unchanged at 0.
- CNT_WIDTH=2, 5 consecutive addi -> retired reads 1,2,3,3,3 (saturation, no wrap).
